// File: rtl/mod_pkg.sv
// Shared types and constants for the centered modulo lift (mod_center_lift).
package mod_pkg;

  localparam int unsigned NW_DEF = 13;
  localparam int unsigned MW_DEF = 12;
  localparam int unsigned Q_TEST = 4621;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    CENT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mod_center_step.sv
// One restoring-division iteration: shift in the dividend MSB, conditionally subtract.
module mod_center_step
  import mod_pkg::*;
#(
  parameter int unsigned MW = MW_DEF
) (
  input  logic [MW-1:0] r_i,
  input  logic          d_msb_i,
  input  logic [MW-1:0] m_i,
  output logic [MW:0]   r_o,
  output logic          q_o
);

  logic [MW:0] r_sh;
  logic [MW:0] m_ext;

  // Compare and subtract at MW+1 bits so the shifted remainder never overflows
  always_comb begin
    r_sh  = {r_i, d_msb_i};
    m_ext = {1'b0, m_i};
    q_o   = (r_sh >= m_ext);
    r_o   = q_o ? (r_sh - m_ext) : r_sh;
  end

endmodule

// File: rtl/mod_center_lift.sv
// Centered signed representative of X mod M via NW-cycle restoring division.
// Optional quotient output enabled by defining MOD_CENTER_QUOT_EN.
module mod_center_lift
  import mod_pkg::*;
#(
  parameter int unsigned NW = NW_DEF,
  parameter int unsigned MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] X,
  input  logic [MW-1:0] M,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] mod_c,
  output logic          err
`ifdef MOD_CENTER_QUOT_EN
  ,
  output logic [NW-1:0] quot
`endif
);

  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

  state_t        state_q, state_d;
  logic [NW-1:0] d_q, d_d;
  logic [MW-1:0] mr_q, mr_d;
  logic [MW:0]   r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [NW-1:0] mod_q, mod_d;
  logic          err_q, err_d;
`ifdef MOD_CENTER_QUOT_EN
  logic [NW-1:0] quot_q, quot_d;
`endif

  logic [MW:0]   step_r;
  logic          step_qbit;
  logic [MW:0]   mr_ext;
  logic [MW:0]   half;
  logic [NW-1:0] neg_val;

  mod_center_step #(.MW(MW)) u_step (
    .r_i     (r_q[MW-1:0]),
    .d_msb_i (d_q[NW-1]),
    .m_i     (mr_q),
    .r_o     (step_r),
    .q_o     (step_qbit)
  );

  // Next-state and datapath update for the IDLE/DIV/CENT/DONE sequence
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    mr_d    = mr_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mod_d   = mod_q;
    err_d   = err_q;
`ifdef MOD_CENTER_QUOT_EN
    quot_d  = quot_q;
`endif
    mr_ext  = {1'b0, mr_q};
    half    = (mr_ext - (MW+1)'(1)) >> 1;
    neg_val = NW'(r_q) - NW'(mr_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          d_d     = X;
          mr_d    = M;
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        r_d   = step_r;
        d_d   = {d_q[NW-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NW - 1)) begin
          state_d = CENT;
        end
      end
      CENT: begin
        if (mr_q == '0) begin
          mod_d = '0;
          err_d = 1'b1;
`ifdef MOD_CENTER_QUOT_EN
          quot_d = '0;
`endif
        end else begin
          mod_d = (r_q > half) ? neg_val : NW'(r_q);
          err_d = 1'b0;
`ifdef MOD_CENTER_QUOT_EN
          quot_d = d_q;
`endif
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      mr_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mod_q   <= '0;
      err_q   <= 1'b0;
`ifdef MOD_CENTER_QUOT_EN
      quot_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      mr_q    <= mr_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mod_q   <= mod_d;
      err_q   <= err_d;
`ifdef MOD_CENTER_QUOT_EN
      quot_q  <= quot_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign mod_c = mod_q;
  assign err   = err_q;
`ifdef MOD_CENTER_QUOT_EN
  assign quot  = quot_q;
`endif

endmodule

// File: tb/tb_mod_center_lift.sv
// Self-checking bench for mod_center_lift against an arithmetic reference model.
// The modulus 4621 needs 13 bits, so the DUT is built with NW=14, MW=13 here;
// latency and issue spacing are checked against NW+1 and NW+3 accordingly.
module tb_mod_center_lift;
  import mod_pkg::*;

  localparam int unsigned TB_NW = 14;
  localparam int unsigned TB_MW = 13;
  localparam int LAT = TB_NW + 1;
  localparam int GAP = TB_NW + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [TB_NW-1:0] X = '0;
  logic [TB_MW-1:0] M = '0;
  logic             busy;
  logic             done;
  logic [TB_NW-1:0] mod_c;
  logic             err;
`ifdef MOD_CENTER_QUOT_EN
  logic [TB_NW-1:0] quot;
`endif

  int tests_run = 0;
  int fails = 0;

  mod_center_lift #(.NW(TB_NW), .MW(TB_MW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .M     (M),
    .busy  (busy),
    .done  (done),
    .mod_c (mod_c),
    .err   (err)
`ifdef MOD_CENTER_QUOT_EN
    ,
    .quot  (quot)
`endif
  );

  always #5 clk = ~clk;

  // Centered representative in [-floor(m/2), floor((m-1)/2)]
  function automatic logic [TB_NW-1:0] ref_mod(input int x, input int m);
    int r;
    if (m == 0) return '0;
    r = x % m;
    if (r > (m - 1) / 2) r = r - m;
    return TB_NW'(r);
  endfunction

  function automatic logic [TB_NW-1:0] ref_quot(input int x, input int m);
    if (m == 0) return '0;
    return TB_NW'(x / m);
  endfunction

  // Issue one operation from IDLE and check latency and results
  task automatic run_op(input int x, input int m, input string name);
    int  k;
    bit  seen;
    X = TB_NW'(x);
    M = TB_MW'(m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    X = TB_NW'($urandom);
    M = TB_MW'($urandom);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_start: got %b, expected 1", name, busy);
    end
    seen = 1'b0;
    for (k = 1; k <= LAT + 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen || k != LAT) begin
      fails++;
      $display("FAIL %s latency: got %0d edges (seen=%0b), expected %0d", name, k, seen, LAT);
    end
    if (seen) begin
      tests_run++;
      if (mod_c !== ref_mod(x, m) || err !== (m == 0) || busy !== 1'b0) begin
        fails++;
        $display("FAIL %s result x=%0d m=%0d: got mod_c=%0d err=%b busy=%b, expected mod_c=%0d err=%b busy=0",
                 name, x, m, $signed(mod_c), err, busy, $signed(ref_mod(x, m)), (m == 0));
      end
`ifdef MOD_CENTER_QUOT_EN
      tests_run++;
      if (quot !== ref_quot(x, m)) begin
        fails++;
        $display("FAIL %s quot x=%0d m=%0d: got %0d, expected %0d", name, x, m, quot, ref_quot(x, m));
      end
`endif
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL %s done_one_cycle: got %b, expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || mod_c !== '0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got busy=%b done=%b mod_c=%h err=%b, expected all 0", busy, done, mod_c, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || mod_c !== '0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got busy=%b done=%b mod_c=%h err=%b, expected all 0", busy, done, mod_c, err);
    end
  endtask

  task automatic test_directed();
    run_op(5000, int'(Q_TEST), "q_5000");
    run_op(4620, int'(Q_TEST), "q_4620");
    run_op(8191, int'(Q_TEST), "q_8191");
    run_op(100, int'(Q_TEST), "x_lt_m");
    for (int i = 0; i < 8; i++) run_op(i, 3, "m3_sweep");
    run_op(2, 4, "m4_half");
    run_op(6, 12, "m12_half");
    run_op(9999, 1, "m1");
    run_op(123, 0, "m0_err");
    run_op(7, 5, "after_err");
  endtask

  task automatic test_random();
    int x;
    int m;
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, (1 << TB_NW) - 1));
      case ($urandom_range(0, 9))
        0:       m = 0;
        1, 2:    m = int'($urandom_range(1, 16));
        default: m = int'($urandom_range(1, (1 << TB_MW) - 1));
      endcase
      run_op(x, m, "random");
    end
  endtask

  // start held high: accepted only in IDLE, one done per accepted start
  task automatic test_back_to_back();
    int pos[$];
    int k;
    bit seen;
    X = TB_NW'(8191);
    M = TB_MW'(Q_TEST);
    start = 1'b1;
    for (int i = 0; i < 3 * GAP + 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pos.push_back(i);
        tests_run++;
        if (mod_c !== ref_mod(8191, int'(Q_TEST))) begin
          fails++;
          $display("FAIL b2b_result: got %0d, expected %0d", $signed(mod_c), $signed(ref_mod(8191, int'(Q_TEST))));
        end
      end
    end
    start = 1'b0;
    tests_run++;
    if (pos.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d dones, expected 3", pos.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        tests_run++;
        if (pos[j] != LAT + j * GAP) begin
          fails++;
          $display("FAIL b2b_spacing[%0d]: got edge %0d, expected %0d", j, pos[j], LAT + j * GAP);
        end
      end
    end
    seen = 1'b0;
    for (k = 0; k < LAT + 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      fails++;
      $display("FAIL b2b_drain: got no done within %0d edges, expected one", LAT + 10);
    end
    @(posedge clk); #1;
  endtask

  // start pulses during DIV/CENT and DONE must be ignored
  task automatic test_busy_ignore();
    int  k;
    bit  seen;
    X = TB_NW'(5000);
    M = TB_MW'(Q_TEST);
    start = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    for (k = 1; k <= LAT + 10; k++) begin
      start = (k % 2 == 1) && (k < LAT - 1);
      X = TB_NW'($urandom);
      M = TB_MW'($urandom);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen || k != LAT || mod_c !== ref_mod(5000, int'(Q_TEST))) begin
      fails++;
      $display("FAIL ignore_busy: got edge %0d mod_c=%0d, expected edge %0d mod_c=%0d",
               k, $signed(mod_c), LAT, $signed(ref_mod(5000, int'(Q_TEST))));
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_done_start: got busy=%b done=%b, expected 0 0", busy, done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_idle_after: got busy=%b, expected 0", busy);
    end
  endtask

  // Asynchronous reset mid-run aborts without a done pulse
  task automatic test_rst_mid();
    bit saw_done;
    X = TB_NW'(8191);
    M = TB_MW'(Q_TEST);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || mod_c !== '0 || err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_immediate: got busy=%b done=%b mod_c=%h err=%b, expected all 0", busy, done, mod_c, err);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done) begin
      fails++;
      $display("FAIL rst_mid_quiet: got activity after abort, expected none");
    end
    run_op(7, 5, "after_rst");
    run_op(8191, int'(Q_TEST), "after_rst_q");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
